// File: rtl/rst_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
// State encodings are exposed on o_state for status readback.
package rst_sequencer_pkg;

  localparam int RST_SEQ_CNT_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PLL = 3'd1,
    ST_DDR_RST  = 3'd2,
    ST_WAIT_DDR = 3'd3,
    ST_DBG_REL  = 3'd4,
    ST_RUN      = 3'd5
  } rst_state_e;

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Synchronous active-high reset clears both stages.
module cdc_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: PLL lock qualification, DDR reset/calibration,
// then debug-domain release ahead of system-domain release.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int unsigned lock_filter    = 16,
  parameter int unsigned ddr_rst_cycles = 64,
  parameter int unsigned ddr_timeout    = 2000000,
  parameter int unsigned sys_hold       = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sys_locked,
  input  logic       i_ddr_calib,
  input  logic       i_dmireset,
  output logic       o_ddr_rst,
  output logic       o_dbg_nrst,
  output logic       o_sys_rst,
  output logic       o_sys_nrst,
  output logic       o_fault,
  output logic [2:0] o_state
);

  localparam int W = RST_SEQ_CNT_W;

  localparam logic [W-1:0] LOCK_LAST = W'(lock_filter - 1);
  localparam logic [W-1:0] DDR_LAST  = W'(ddr_rst_cycles - 1);
  localparam logic [W-1:0] TO_LAST   = W'(ddr_timeout - 1);
  localparam logic [W-1:0] HOLD_LAST = W'(sys_hold - 1);

  logic lock_s;
  logic calib_s;

  rst_state_e   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         fault_q, fault_d;
  logic         ddr_rst_q, ddr_rst_d;
  logic         dbg_nrst_q, dbg_nrst_d;
  logic         sys_rst_q, sys_rst_d;

  cdc_sync2 u_sync_lock (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_sys_locked),
    .o_q   (lock_s)
  );

  cdc_sync2 u_sync_calib (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_ddr_calib),
    .o_q   (calib_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + W'(1);
    fault_d = fault_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT_PLL;
        cnt_d   = '0;
      end
      ST_WAIT_PLL: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_DDR_RST;
          cnt_d   = '0;
        end
      end
      ST_DDR_RST: begin
        if (cnt_q == DDR_LAST) begin
          state_d = ST_WAIT_DDR;
          cnt_d   = '0;
        end
      end
      ST_WAIT_DDR: begin
        if (calib_s) begin
          state_d = ST_DBG_REL;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_DDR_RST;
          cnt_d   = '0;
          fault_d = 1'b1;
        end
      end
      ST_DBG_REL: begin
        // A held debug-module request parks the hold count at zero
        if (i_dmireset) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_q != ST_IDLE && state_q != ST_WAIT_PLL) begin
      if (!lock_s) begin
        state_d = ST_WAIT_PLL;
        cnt_d   = '0;
        fault_d = fault_q;
      end else if (!calib_s &&
                   (state_q == ST_DBG_REL ||
                    state_q == ST_RUN)) begin
        state_d = ST_DDR_RST;
        cnt_d   = '0;
      end else if (i_dmireset && state_q == ST_RUN) begin
        state_d = ST_DBG_REL;
        cnt_d   = '0;
      end
    end
  end

  // Outputs are decoded from the next state so they land with o_state
  always_comb begin
    ddr_rst_d  = 1'b1;
    dbg_nrst_d = 1'b0;
    sys_rst_d  = 1'b1;
    unique case (state_d)
      ST_WAIT_DDR: begin
        ddr_rst_d = 1'b0;
      end
      ST_DBG_REL: begin
        ddr_rst_d  = 1'b0;
        dbg_nrst_d = 1'b1;
      end
      ST_RUN: begin
        ddr_rst_d  = 1'b0;
        dbg_nrst_d = 1'b1;
        sys_rst_d  = 1'b0;
      end
      default: begin
        ddr_rst_d  = 1'b1;
        dbg_nrst_d = 1'b0;
        sys_rst_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
      ddr_rst_q  <= 1'b1;
      dbg_nrst_q <= 1'b0;
      sys_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      ddr_rst_q  <= ddr_rst_d;
      dbg_nrst_q <= dbg_nrst_d;
      sys_rst_q  <= sys_rst_d;
    end
  end

  assign o_ddr_rst  = ddr_rst_q;
  assign o_dbg_nrst = dbg_nrst_q;
  assign o_sys_rst  = sys_rst_q;
  assign o_sys_nrst = ~sys_rst_q;
  assign o_fault    = fault_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with small parameters.
// Inputs change 1ns after a rising edge; outputs are checked there.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       calib;
  logic       dmi;
  logic       ddr_rst;
  logic       dbg_nrst;
  logic       sys_rst;
  logic       sys_nrst;
  logic       fault;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .lock_filter    (4),
    .ddr_rst_cycles (8),
    .ddr_timeout    (100),
    .sys_hold       (16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sys_locked (lock),
    .i_ddr_calib  (calib),
    .i_dmireset   (dmi),
    .o_ddr_rst    (ddr_rst),
    .o_dbg_nrst   (dbg_nrst),
    .o_sys_rst    (sys_rst),
    .o_sys_nrst   (sys_nrst),
    .o_fault      (fault),
    .o_state      (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; lock = 1'b0; calib = 1'b0; dmi = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // IDLE -> WAIT_PLL, lock, DDR reset, calib, hold -> RUN
  task automatic bring_to_run();
    apply_reset();
    tick();
    lock = 1'b1;
    repeat (14) tick();
    calib = 1'b1;
    repeat (19) tick();
    n_chk++;
    if (state !== 3'd5) begin
      n_fail++;
      $display("FAIL run_entry state=%0d exp=5", state);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if ({ddr_rst, dbg_nrst, sys_rst, sys_nrst, fault, state} !== 8'b1010_0000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=10100000",
               {ddr_rst, dbg_nrst, sys_rst, sys_nrst, fault, state});
    end
    tick();
    n_chk++;
    if (state !== 3'd1 || ddr_rst !== 1'b1 || sys_nrst !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_to_wait_pll state=%0d ddr=%b sysn=%b exp=1,1,0",
               state, ddr_rst, sys_nrst);
    end
  endtask

  task automatic test_power_up();
    logic [2:0] es;
    apply_reset();
    repeat (2) tick();
    lock = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      es = (i < 6) ? 3'd1 : (i < 14) ? 3'd2 : 3'd3;
      n_chk++;
      if (state !== es || ddr_rst !== (i < 14)) begin
        n_fail++;
        $display("FAIL pwr_lock_seq cyc=%0d state=%0d ddr=%b exp=%0d,%b",
                 i, state, ddr_rst, es, (i < 14));
      end
    end
    calib = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (dbg_nrst !== 1'b0) begin
      n_fail++;
      $display("FAIL pwr_dbg_early got=%b exp=0", dbg_nrst);
    end
    tick();
    n_chk++;
    if (dbg_nrst !== 1'b1 || state !== 3'd4 || sys_nrst !== 1'b0) begin
      n_fail++;
      $display("FAIL pwr_dbg_rel dbgn=%b state=%0d sysn=%b exp=1,4,0",
               dbg_nrst, state, sys_nrst);
    end
    repeat (15) tick();
    n_chk++;
    if (sys_nrst !== 1'b0) begin
      n_fail++;
      $display("FAIL pwr_sys_early got=%b exp=0", sys_nrst);
    end
    tick();
    n_chk++;
    if (sys_nrst !== 1'b1 || sys_rst !== 1'b0 || state !== 3'd5 ||
        ddr_rst !== 1'b0 || dbg_nrst !== 1'b1) begin
      n_fail++;
      $display("FAIL pwr_run sysn=%b sys=%b state=%0d ddr=%b dbgn=%b exp=1,0,5,0,1",
               sys_nrst, sys_rst, state, ddr_rst, dbg_nrst);
    end
  endtask

  task automatic test_lock_glitch();
    logic [2:0] es;
    apply_reset();
    tick();
    lock = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) lock = 1'b0;
      if (i == 4) lock = 1'b1;
      es = (i < 10) ? 3'd1 : 3'd2;
      n_chk++;
      if (state !== es) begin
        n_fail++;
        $display("FAIL glitch_filter cyc=%0d state=%0d exp=%0d", i, state, es);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    tick();
    lock = 1'b1;
    repeat (14) tick();
    repeat (99) tick();
    n_chk++;
    if (fault !== 1'b0 || state !== 3'd3 || ddr_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL to_before fault=%b state=%0d ddr=%b exp=0,3,0",
               fault, state, ddr_rst);
    end
    tick();
    n_chk++;
    if (fault !== 1'b1 || state !== 3'd2 || ddr_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL to_expire fault=%b state=%0d ddr=%b exp=1,2,1",
               fault, state, ddr_rst);
    end
    repeat (7) tick();
    n_chk++;
    if (ddr_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL to_pulse_len ddr=%b exp=1", ddr_rst);
    end
    tick();
    n_chk++;
    if (ddr_rst !== 1'b0 || state !== 3'd3) begin
      n_fail++;
      $display("FAIL to_pulse_end ddr=%b state=%0d exp=0,3", ddr_rst, state);
    end
    calib = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (state !== 3'd4 || fault !== 1'b1 || dbg_nrst !== 1'b1) begin
      n_fail++;
      $display("FAIL to_retry state=%0d fault=%b dbgn=%b exp=4,1,1",
               state, fault, dbg_nrst);
    end
  endtask

  task automatic test_dmireset();
    bring_to_run();
    dmi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (sys_nrst !== 1'b0 || dbg_nrst !== 1'b1 || state !== 3'd4) begin
        n_fail++;
        $display("FAIL dmi_hold cyc=%0d sysn=%b dbgn=%b state=%0d exp=0,1,4",
                 i, sys_nrst, dbg_nrst, state);
      end
    end
    dmi = 1'b0;
    repeat (15) tick();
    n_chk++;
    if (sys_nrst !== 1'b0 || dbg_nrst !== 1'b1) begin
      n_fail++;
      $display("FAIL dmi_early sysn=%b dbgn=%b exp=0,1", sys_nrst, dbg_nrst);
    end
    tick();
    n_chk++;
    if (sys_nrst !== 1'b1 || state !== 3'd5) begin
      n_fail++;
      $display("FAIL dmi_release sysn=%b state=%0d exp=1,5", sys_nrst, state);
    end
  endtask

  task automatic test_lock_loss();
    bring_to_run();
    lock = 1'b0;
    repeat (2) tick();
    n_chk++;
    if (state !== 3'd5 || sys_nrst !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_early state=%0d sysn=%b exp=5,1", state, sys_nrst);
    end
    tick();
    n_chk++;
    if (state !== 3'd1 || sys_nrst !== 1'b0 || dbg_nrst !== 1'b0 ||
        ddr_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_reset state=%0d sysn=%b dbgn=%b ddr=%b exp=1,0,0,1",
               state, sys_nrst, dbg_nrst, ddr_rst);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tick();
    lock = 1'b1;
    repeat (114) tick();
    repeat (3) tick();
    n_chk++;
    if (state !== 3'd2 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup state=%0d fault=%b exp=2,1", state, fault);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({ddr_rst, dbg_nrst, sys_rst, sys_nrst, fault, state} !== 8'b1010_0000) begin
      n_fail++;
      $display("FAIL mid_reset got=%b exp=10100000",
               {ddr_rst, dbg_nrst, sys_rst, sys_nrst, fault, state});
    end
  endtask

  initial begin
    rst = 1'b1; lock = 1'b0; calib = 1'b0; dmi = 1'b0;
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_timeout();
    test_dmireset();
    test_lock_loss();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
